// File: rtl/lcd_timing_pkg.sv
// Timing constants and helpers for the parallel RGB LCD timing generator.
// Standard panel timing sets plus derived total/active-start arithmetic.
package lcd_timing_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CNT_W-1:0] sync;
        logic [CNT_W-1:0] back;
        logic [CNT_W-1:0] disp;
        logic [CNT_W-1:0] front;
    } lcd_axis_t;

    typedef struct packed {
        lcd_axis_t h;
        lcd_axis_t v;
    } lcd_timing_t;

    localparam lcd_timing_t LCD_480X272 = '{
        h: '{sync: 11'd41,  back: 11'd2,   disp: 11'd480,  front: 11'd2},
        v: '{sync: 11'd10,  back: 11'd2,   disp: 11'd272,  front: 11'd2}
    };

    localparam lcd_timing_t LCD_800X480 = '{
        h: '{sync: 11'd128, back: 11'd88,  disp: 11'd800,  front: 11'd40},
        v: '{sync: 11'd2,   back: 11'd33,  disp: 11'd480,  front: 11'd10}
    };

    localparam lcd_timing_t LCD_1024X600 = '{
        h: '{sync: 11'd20,  back: 11'd140, disp: 11'd1024, front: 11'd160},
        v: '{sync: 11'd3,   back: 11'd20,  disp: 11'd600,  front: 11'd12}
    };

    // Computed in int so an oversized parameter set cannot silently wrap.
    function automatic int axis_total(input int s, input int b,
                                      input int d, input int f);
        return s + b + d + f;
    endfunction

    function automatic int axis_start(input int s, input int b);
        return s + b;
    endfunction

    function automatic int timing_h_total(input lcd_timing_t t);
        return axis_total(int'(t.h.sync), int'(t.h.back),
                          int'(t.h.disp), int'(t.h.front));
    endfunction

    function automatic int timing_v_total(input lcd_timing_t t);
        return axis_total(int'(t.v.sync), int'(t.v.back),
                          int'(t.v.disp), int'(t.v.front));
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// One timing axis: wrapping counter with sync, active and
// request-window decodes; the request window may lead active by LEAD.
module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int   TOTAL    = 15,
    parameter int   SYNC     = 2,
    parameter int   START    = 5,
    parameter int   DISP     = 8,
    parameter int   LEAD     = 0,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_sync,
    output logic             o_act,
    output logic             o_req,
    output logic [CNT_W-1:0] o_pos
);

    localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] L_SYNC   = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] L_ACT_LO = CNT_W'(START);
    localparam logic [CNT_W-1:0] L_ACT_HI = CNT_W'(START + DISP);
    localparam logic [CNT_W-1:0] L_REQ_LO = CNT_W'(START - LEAD);
    localparam logic [CNT_W-1:0] L_REQ_HI = CNT_W'(START + DISP - LEAD);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == L_LAST);
    assign o_wrap    = i_en && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_sync = (r_cnt < L_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign o_act  = (r_cnt >= L_ACT_LO) && (r_cnt < L_ACT_HI);
    assign o_req  = (r_cnt >= L_REQ_LO) && (r_cnt < L_REQ_HI);
    assign o_pos  = o_req ? (r_cnt - L_REQ_LO) : '0;

endmodule

// File: rtl/lcd_driver.sv
// RGB LCD timing generator: HS/VS/DE, look-ahead pixel request
// coordinates, and pixel sink driving the panel data bus.
module lcd_driver
    import lcd_timing_pkg::*;
#(
    parameter logic [10:0] H_SYNC   = 11'd41,
    parameter logic [10:0] H_BACK   = 11'd2,
    parameter logic [10:0] H_DISP   = 11'd480,
    parameter logic [10:0] H_FRONT  = 11'd2,
    parameter logic [10:0] V_SYNC   = 11'd10,
    parameter logic [10:0] V_BACK   = 11'd2,
    parameter logic [10:0] V_DISP   = 11'd272,
    parameter logic [10:0] V_FRONT  = 11'd2,
    parameter logic        SYNC_POL = 1'b0,
    parameter int          WIDTH    = 24
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pixel_data,
    output logic [10:0]      pixel_xpos,
    output logic [10:0]      pixel_ypos,
    output logic [10:0]      h_disp,
    output logic [10:0]      v_disp,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [WIDTH-1:0] lcd_rgb,
    output logic             lcd_bl,
    output logic             frame_start
);

    localparam int H_TOTAL = axis_total(int'(H_SYNC), int'(H_BACK),
                                        int'(H_DISP), int'(H_FRONT));
    localparam int V_TOTAL = axis_total(int'(V_SYNC), int'(V_BACK),
                                        int'(V_DISP), int'(V_FRONT));
    localparam int HA      = axis_start(int'(H_SYNC), int'(H_BACK));
    localparam int VA      = axis_start(int'(V_SYNC), int'(V_BACK));

    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
        $error("lcd_driver: timing totals exceed 11-bit counter range");
    end
    if (HA < 1) begin : g_bad_ha
        $error("lcd_driver: H_SYNC+H_BACK must be at least 1");
    end

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_h_req;
    logic             w_v_req;
    logic [CNT_W-1:0] w_h_pos;
    logic [CNT_W-1:0] w_v_pos;
    logic             w_data_req;
    logic             w_de;

    // Horizontal request window leads DE by one pclk for lcd_display's latency.
    lcd_sync_counter #(
        .TOTAL    (H_TOTAL),
        .SYNC     (int'(H_SYNC)),
        .START    (HA),
        .DISP     (int'(H_DISP)),
        .LEAD     (1),
        .SYNC_POL (SYNC_POL)
    ) u_h_cnt (
        .clk    (lcd_pclk),
        .rst_n  (rst_n),
        .i_en   (1'b1),
        .o_cnt  (w_h_cnt),
        .o_wrap (w_h_wrap),
        .o_sync (w_h_sync),
        .o_act  (w_h_act),
        .o_req  (w_h_req),
        .o_pos  (w_h_pos)
    );

    lcd_sync_counter #(
        .TOTAL    (V_TOTAL),
        .SYNC     (int'(V_SYNC)),
        .START    (VA),
        .DISP     (int'(V_DISP)),
        .LEAD     (0),
        .SYNC_POL (SYNC_POL)
    ) u_v_cnt (
        .clk    (lcd_pclk),
        .rst_n  (rst_n),
        .i_en   (w_h_wrap),
        .o_cnt  (w_v_cnt),
        .o_wrap (w_v_wrap),
        .o_sync (w_v_sync),
        .o_act  (w_v_act),
        .o_req  (w_v_req),
        .o_pos  (w_v_pos)
    );

    assign w_data_req = w_v_act && w_h_req;
    assign w_de       = w_v_act && w_h_act;

    // Outputs are gated by rst_n so reset values appear without a clock.
    assign lcd_hs      = rst_n ? w_h_sync : ~SYNC_POL;
    assign lcd_vs      = rst_n ? w_v_sync : ~SYNC_POL;
    assign lcd_de      = rst_n && w_de;
    assign lcd_bl      = rst_n;
    assign frame_start = rst_n && (w_h_cnt == '0) && (w_v_cnt == '0);
    assign pixel_xpos  = (rst_n && w_data_req) ? w_h_pos : '0;
    assign pixel_ypos  = (rst_n && w_v_req) ? w_v_pos : '0;
    assign lcd_rgb     = lcd_de ? pixel_data : '0;

    assign h_disp = H_DISP;
    assign v_disp = V_DISP;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with a small 15x8 timing and a
// one-cycle registered pixel source standing in for lcd_display.
module tb_lcd_driver;

    logic        clk;
    logic        rst_n;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    lcd_driver #(
        .H_SYNC   (11'd2),
        .H_BACK   (11'd3),
        .H_DISP   (11'd8),
        .H_FRONT  (11'd2),
        .V_SYNC   (11'd1),
        .V_BACK   (11'd2),
        .V_DISP   (11'd4),
        .V_FRONT  (11'd1),
        .SYNC_POL (1'b0),
        .WIDTH    (24)
    ) dut (
        .lcd_pclk    (clk),
        .rst_n       (rst_n),
        .pixel_data  (pixel_data),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .h_disp      (h_disp),
        .v_disp      (v_disp),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .lcd_bl      (lcd_bl),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        pixel_data <= {13'd0, pixel_ypos[2:0], pixel_xpos[7:0]};

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, c, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hs"},  0, 32'(lcd_hs), 32'd1);
        chk({tag, "_vs"},  0, 32'(lcd_vs), 32'd1);
        chk({tag, "_de"},  0, 32'(lcd_de), 32'd0);
        chk({tag, "_rgb"}, 0, 32'(lcd_rgb), 32'd0);
        chk({tag, "_bl"},  0, 32'(lcd_bl), 32'd0);
        chk({tag, "_x"},   0, 32'(pixel_xpos), 32'd0);
        chk({tag, "_y"},   0, 32'(pixel_ypos), 32'd0);
        chk({tag, "_fs"},  0, 32'(frame_start), 32'd0);
        chk({tag, "_hd"},  0, 32'(h_disp), 32'd8);
        chk({tag, "_vd"},  0, 32'(v_disp), 32'd4);
    endtask

    // c counts pclk cycles since reset release; line = 15, frame = 120.
    task automatic chk_cycle(input int c);
        int  h;
        int  v;
        logic va;
        logic de;
        logic [31:0] ex;
        logic [31:0] ey;
        logic [31:0] er;
        h  = c % 15;
        v  = (c / 15) % 8;
        va = (v >= 3) && (v <= 6);
        de = va && (h >= 5) && (h <= 12);
        ex = (va && h >= 4 && h <= 11) ? 32'(h - 4) : 32'd0;
        ey = va ? 32'(v - 3) : 32'd0;
        er = de ? 32'(((v - 3) << 8) | (h - 5)) : 32'd0;
        chk("hs",  c, 32'(lcd_hs), 32'(h >= 2));
        chk("vs",  c, 32'(lcd_vs), 32'(v >= 1));
        chk("de",  c, 32'(lcd_de), 32'(de));
        chk("x",   c, 32'(pixel_xpos), ex);
        chk("y",   c, 32'(pixel_ypos), ey);
        chk("rgb", c, 32'(lcd_rgb), er);
        chk("fs",  c, 32'(frame_start), 32'(h == 0 && v == 0));
        chk("bl",  c, 32'(lcd_bl), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("rst");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 360; c++) begin
            chk_cycle(c);
            @(negedge clk);
            #1;
        end

        // Now at cycle 360 (frame 4 start); advance to h=7, v=4 mid-DE.
        for (int c = 360; c < 360 + 67; c++) begin
            chk_cycle(c);
            @(negedge clk);
            #1;
        end
        chk_cycle(360 + 67);
        chk("mid_de", 0, 32'(lcd_de), 32'd1);

        rst_n = 1'b0;
        #1;
        chk_reset("async");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("hold");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_fs", 0, 32'(frame_start), 32'd1);
        for (int c = 0; c < 40; c++) begin
            chk_cycle(c);
            @(negedge clk);
            #1;
        end
        chk("end_hd", 0, 32'(h_disp), 32'd8);
        chk("end_vd", 0, 32'(v_disp), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
